qpsk_symbol_serializer: RTL



---
 rtl/qpsk_symbol_serializer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/qpsk_symbol_serializer.sv
// qpsk_symbol_serializer: buffers one frame of QPSK sign bits and streams it as held +/-AMP I/Q samples.
// Define QPSK_SER_UNDERRUN_CNT_EN to add the saturating underrun_cnt output.
module qpsk_symbol_serializer #(
    parameter int SYMS       = 11,
    parameter int OUT_W      = 12,
    parameter int AMP        = 1448,
    parameter int SYM_PERIOD = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SYMS-1:0]         in_real,
    input  logic [SYMS-1:0]         in_imag,
    output logic signed [OUT_W-1:0] out_i,
    output logic signed [OUT_W-1:0] out_q,
    output logic                    out_valid,
    output logic                    sym_strobe,
    output logic                    frame_start,
    output logic                    frame_last,
    output logic                    busy
`ifdef QPSK_SER_UNDERRUN_CNT_EN
    ,
    output logic [7:0]              underrun_cnt
`endif
);

    localparam int IDX_W = (SYMS > 1) ? $clog2(SYMS) : 1;
    localparam int PER_W = (SYM_PERIOD > 1) ? $clog2(SYM_PERIOD) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SYMS - 1);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(SYM_PERIOD - 1);
    localparam logic signed [OUT_W-1:0] POS_AMP = OUT_W'(AMP);
    localparam logic signed [OUT_W-1:0] NEG_AMP = OUT_W'(-AMP);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state, state_next;
    logic [IDX_W-1:0] sym_idx, sym_idx_next;
    logic [PER_W-1:0] per_cnt, per_cnt_next;
    logic [SYMS-1:0]  act_real, act_imag, act_real_next, act_imag_next;
    logic [SYMS-1:0]  hold_real, hold_imag;
    logic             hold_full;
    logic             accept;
    logic             load;

    assign in_ready = !hold_full;
    assign accept   = in_valid && in_ready;
    assign busy     = (state == RUN) || hold_full;

    // Accept and load never coincide: accept needs an empty hold, load a full one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_full <= 1'b0;
            hold_real <= '0;
            hold_imag <= '0;
        end else if (accept) begin
            hold_full <= 1'b1;
            hold_real <= in_real;
            hold_imag <= in_imag;
        end else if (load) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sym_idx  <= '0;
            per_cnt  <= '0;
            act_real <= '0;
            act_imag <= '0;
        end else begin
            state    <= state_next;
            sym_idx  <= sym_idx_next;
            per_cnt  <= per_cnt_next;
            act_real <= act_real_next;
            act_imag <= act_imag_next;
        end
    end

    // The active register shifts left on each symbol advance, so its MSB is always the current symbol.
    always_comb begin
        state_next    = state;
        sym_idx_next  = sym_idx;
        per_cnt_next  = per_cnt;
        act_real_next = act_real;
        act_imag_next = act_imag;
        load          = 1'b0;
        case (state)
            IDLE: begin
                if (hold_full) begin
                    load         = 1'b1;
                    state_next   = RUN;
                    sym_idx_next = '0;
                    per_cnt_next = '0;
                end
            end
            RUN: begin
                if (per_cnt == PER_LAST) begin
                    per_cnt_next = '0;
                    if (sym_idx == IDX_LAST) begin
                        sym_idx_next = '0;
                        if (hold_full) begin
                            load = 1'b1;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        sym_idx_next  = sym_idx + 1'b1;
                        act_real_next = act_real << 1;
                        act_imag_next = act_imag << 1;
                    end
                end else begin
                    per_cnt_next = per_cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (load) begin
            act_real_next = hold_real;
            act_imag_next = hold_imag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_i       <= '0;
            out_q       <= '0;
            out_valid   <= 1'b0;
            sym_strobe  <= 1'b0;
            frame_start <= 1'b0;
            frame_last  <= 1'b0;
        end else if (state == RUN) begin
            out_i       <= act_real[SYMS-1] ? POS_AMP : NEG_AMP;
            out_q       <= act_imag[SYMS-1] ? POS_AMP : NEG_AMP;
            out_valid   <= 1'b1;
            sym_strobe  <= (per_cnt == '0);
            frame_start <= (per_cnt == '0) && (sym_idx == '0);
            frame_last  <= (sym_idx == IDX_LAST);
        end else begin
            out_i       <= '0;
            out_q       <= '0;
            out_valid   <= 1'b0;
            sym_strobe  <= 1'b0;
            frame_start <= 1'b0;
            frame_last  <= 1'b0;
        end
    end

`ifdef QPSK_SER_UNDERRUN_CNT_EN
    logic run_end;
    assign run_end = (state == RUN) && (state_next == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_cnt <= 8'd0;
        end else if (run_end && (underrun_cnt != 8'hFF)) begin
            underrun_cnt <= underrun_cnt + 8'd1;
        end
    end
`endif

endmodule
